// File: rtl/conv_pkg.sv
// Shared codes for the convolution result path: crw encodings, display modes,
// result-memory addresses and the display sequencer state encoding.
package conv_pkg;

  localparam logic [1:0] CRW_READ  = 2'b11;
  localparam logic [1:0] CRW_WRITE = 2'b10;
  localparam logic [1:0] CRW_IDLE  = 2'b00;

  localparam logic [1:0] MODE_NONE   = 2'b00;
  localparam logic [1:0] MODE_SERIAL = 2'b01;
  localparam logic [1:0] MODE_P3X3   = 2'b10;
  localparam logic [1:0] MODE_P2X2   = 2'b11;

  // Result memory map: serial, then 3x3-parallel, then 2x2-parallel, each C11..C22
  localparam logic [4:0] ADDR_SER_C11 = 5'd0;
  localparam logic [4:0] ADDR_SER_C12 = 5'd1;
  localparam logic [4:0] ADDR_SER_C21 = 5'd2;
  localparam logic [4:0] ADDR_SER_C22 = 5'd3;
  localparam logic [4:0] ADDR_P3_C11  = 5'd4;
  localparam logic [4:0] ADDR_P3_C12  = 5'd5;
  localparam logic [4:0] ADDR_P3_C21  = 5'd6;
  localparam logic [4:0] ADDR_P3_C22  = 5'd7;
  localparam logic [4:0] ADDR_P2_C11  = 5'd8;
  localparam logic [4:0] ADDR_P2_C12  = 5'd9;
  localparam logic [4:0] ADDR_P2_C21  = 5'd10;
  localparam logic [4:0] ADDR_P2_C22  = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_SHOW,
    ST_DONE
  } state_t;

endpackage

// File: rtl/result_display_sequencer_dwell_counter.sv
// Dwell counter: synchronous clear has priority over enable; o_tc flags the
// terminal count DWELL_MAX.
module dwell_counter #(
  parameter int DWELL_MAX = 99999999,
  parameter int CNT_W     = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL_MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/result_display_sequencer.sv
// Sweeps the 12 convolution results out of result memory, showing each for a
// dwell period. Define RESULT_DISPLAY_SEQUENCER_LOOP_EN to repeat sweeps forever.
module result_display_sequencer
  import conv_pkg::*;
#(
  parameter int DWELL_MAX   = 99999999,
  parameter int CNT_W       = 27,
  parameter int NUM_RESULTS = 12,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              step,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [4:0]        mem_addr,
  output logic [1:0]        mem_rw,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic [3:0]        disp_idx,
  output logic [1:0]        disp_mode,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
);

  state_t     r_state, w_next;
  logic [3:0] r_idx;
  logic       r_done;
  logic       w_tc, w_adv, w_last, w_cnt_clr, w_cnt_en;
  logic [1:0] w_mode;

  assign w_last    = (r_idx == 4'(NUM_RESULTS-1));
  // Manual step only counts while paused; otherwise the dwell timer rules.
  assign w_adv     = (r_state == ST_SHOW) && ((w_tc && !pause) || (pause && step));
  assign w_cnt_en  = (r_state == ST_SHOW) && !pause;
  assign w_cnt_clr = (r_state != ST_SHOW) || w_adv;

  dwell_counter #(.DWELL_MAX(DWELL_MAX), .CNT_W(CNT_W)) u_dwell (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = ST_REQ;
      ST_REQ:       if (mem_gnt) w_next = ST_WAIT_DATA;
      ST_WAIT_DATA: w_next = ST_SHOW;
      ST_SHOW: if (w_adv) begin
`ifdef RESULT_DISPLAY_SEQUENCER_LOOP_EN
        w_next = ST_REQ;
`else
        w_next = w_last ? ST_DONE : ST_REQ;
`endif
      end
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    if (r_idx < 4'd4)      w_mode = MODE_SERIAL;
    else if (r_idx < 4'd8) w_mode = MODE_P3X3;
    else                   w_mode = MODE_P2X2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx      <= '0;
      r_done     <= 1'b0;
      disp_data  <= '0;
      disp_idx   <= '0;
      disp_mode  <= MODE_NONE;
      disp_valid <= 1'b0;
    end else begin
      r_done <= w_adv && w_last;
      if (r_state == ST_IDLE && start) begin
        r_idx      <= '0;
        disp_data  <= '0;
        disp_idx   <= '0;
        disp_mode  <= MODE_NONE;
        disp_valid <= 1'b0;
      end
      if (r_state == ST_WAIT_DATA) begin
        disp_data  <= mem_rdata;
        disp_idx   <= r_idx;
        disp_mode  <= w_mode;
        disp_valid <= 1'b1;
      end
      if (w_adv) r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
    end
  end

  assign mem_req  = (r_state == ST_REQ);
  assign mem_rw   = mem_req ? CRW_READ : CRW_IDLE;
  assign mem_addr = {1'b0, r_idx};
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule
